// File: rtl/ascon_release_ctrl_if.sv
// Host-facing bundle for ascon_release_ctrl: voted crypto results in, released result out.
// The slave modport is the controller's view; master is the driving environment's view.
interface ascon_release_ctrl_if #(
  parameter int unsigned y = 40
) ();
  logic [y-1:0]  cipher_text;
  logic [127:0]  tag;
  logic          encryption_ready;
  logic [y-1:0]  dec_plain_text;
  logic [127:0]  dec_tag;
  logic          decryption_ready;
  logic          message_authentication;
  logic [y-1:0]  out_data;
  logic [127:0]  out_tag;
  logic          out_kind;
  logic          out_valid;
  logic          out_ready;
  logic          auth_fail;
  logic [7:0]    fail_count;
  logic          overflow;
  logic          locked;

  modport slave (
    input  cipher_text, tag, encryption_ready,
    input  dec_plain_text, dec_tag, decryption_ready, message_authentication,
    input  out_ready,
    output out_data, out_tag, out_kind, out_valid,
    output auth_fail, fail_count, overflow, locked
  );

  modport master (
    output cipher_text, tag, encryption_ready,
    output dec_plain_text, dec_tag, decryption_ready, message_authentication,
    output out_ready,
    input  out_data, out_tag, out_kind, out_valid,
    input  auth_fail, fail_count, overflow, locked
  );
endinterface

// File: rtl/ascon_release_ctrl.sv
// Release controller for Ascon results: captures encryption/decryption results on the rising
// edge of their ready levels, holds them behind a valid/ready handshake with a one-deep pending
// slot, suppresses unauthenticated plaintext and counts authentication failures.
// Optional lockout after FAIL_LIMIT failures is enabled by defining ASCON_RELEASE_LOCKOUT_EN.
module ascon_release_ctrl #(
  parameter int unsigned y          = 40,
  parameter int unsigned FAIL_LIMIT = 3
) (
  input logic                 clk,
  input logic                 rst,
  ascon_release_ctrl_if.slave bus_io
);

`ifdef ASCON_RELEASE_LOCKOUT_EN
  typedef enum logic [1:0] {StIdle, StHold, StLocked} state_e;
  localparam logic [7:0] FailLimit = 8'(FAIL_LIMIT);
`else
  typedef enum logic [1:0] {StIdle, StHold} state_e;
`endif

  if (FAIL_LIMIT < 1 || FAIL_LIMIT > 255) begin : g_bad_fail_limit
    $error("FAIL_LIMIT must be in 1..255");
  end

  state_e         state_q, state_d;
  logic           enc_prev_q, dec_prev_q;
  // Arm flags block capture after reset until the ready level has been seen low.
  logic           enc_arm_q, enc_arm_d, dec_arm_q, dec_arm_d;
  logic [y-1:0]   out_data_q, out_data_d;
  logic [127:0]   out_tag_q, out_tag_d;
  logic           out_kind_q, out_kind_d;
  logic           pend_valid_q, pend_valid_d;
  logic [y-1:0]   pend_data_q, pend_data_d;
  logic [127:0]   pend_tag_q, pend_tag_d;
  logic           pend_kind_q, pend_kind_d;
  logic           pend_auth_q, pend_auth_d;
  logic           auth_fail_q, auth_fail_d;
  logic [7:0]     fail_count_q, fail_count_d;
  logic           overflow_q, overflow_d;

  logic           enc_edge, dec_edge, hs, out_full, pend_full, lock_st;
  logic [y-1:0]   dec_data_m;
  logic [127:0]   dec_tag_m;

`ifdef ASCON_RELEASE_LOCKOUT_EN
  assign lock_st = (state_q == StLocked);
`else
  assign lock_st = 1'b0;
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      enc_prev_q   <= 1'b0;
      dec_prev_q   <= 1'b0;
      enc_arm_q    <= ~bus_io.encryption_ready;
      dec_arm_q    <= ~bus_io.decryption_ready;
      out_data_q   <= '0;
      out_tag_q    <= '0;
      out_kind_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_tag_q   <= '0;
      pend_kind_q  <= 1'b0;
      pend_auth_q  <= 1'b0;
      auth_fail_q  <= 1'b0;
      fail_count_q <= 8'd0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      enc_prev_q   <= bus_io.encryption_ready;
      dec_prev_q   <= bus_io.decryption_ready;
      enc_arm_q    <= enc_arm_d;
      dec_arm_q    <= dec_arm_d;
      out_data_q   <= out_data_d;
      out_tag_q    <= out_tag_d;
      out_kind_q   <= out_kind_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_tag_q   <= pend_tag_d;
      pend_kind_q  <= pend_kind_d;
      pend_auth_q  <= pend_auth_d;
      auth_fail_q  <= auth_fail_d;
      fail_count_q <= fail_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Next-state: retire on handshake first, then place new edges (encryption before decryption)
  // into the output register, else the pending slot, else drop them.
  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_tag_d    = out_tag_q;
    out_kind_d   = out_kind_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_tag_d   = pend_tag_q;
    pend_kind_d  = pend_kind_q;
    pend_auth_d  = pend_auth_q;
    auth_fail_d  = 1'b0;
    fail_count_d = fail_count_q;
    overflow_d   = overflow_q;
    out_full     = 1'b0;
    pend_full    = 1'b0;

    enc_edge  = bus_io.encryption_ready & ~enc_prev_q & enc_arm_q;
    dec_edge  = bus_io.decryption_ready & ~dec_prev_q & dec_arm_q;
    enc_arm_d = enc_arm_q | ~bus_io.encryption_ready;
    dec_arm_d = dec_arm_q | ~bus_io.decryption_ready;
    hs        = (state_q == StHold) & bus_io.out_ready;

    // A rejected decryption never exposes its plaintext or tag.
    dec_data_m = bus_io.message_authentication ? bus_io.dec_plain_text : '0;
    dec_tag_m  = bus_io.message_authentication ? bus_io.dec_tag : '0;

    if (!lock_st) begin
      out_full  = (state_q == StHold) && (!hs || pend_valid_q);
      pend_full = pend_valid_q && !hs;

      if (hs && pend_valid_q) begin
        out_data_d = pend_auth_q ? pend_data_q : '0;
        out_tag_d  = pend_auth_q ? pend_tag_q : '0;
        out_kind_d = pend_kind_q;
      end

      if (enc_edge) begin
        if (!out_full) begin
          out_data_d = bus_io.cipher_text;
          out_tag_d  = bus_io.tag;
          out_kind_d = 1'b0;
          out_full   = 1'b1;
        end else if (!pend_full) begin
          pend_data_d = bus_io.cipher_text;
          pend_tag_d  = bus_io.tag;
          pend_kind_d = 1'b0;
          pend_auth_d = 1'b1;
          pend_full   = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end

      if (dec_edge) begin
        if (!out_full || !pend_full) begin
          if (!out_full) begin
            out_data_d = dec_data_m;
            out_tag_d  = dec_tag_m;
            out_kind_d = 1'b1;
            out_full   = 1'b1;
          end else begin
            pend_data_d = dec_data_m;
            pend_tag_d  = dec_tag_m;
            pend_kind_d = 1'b1;
            pend_auth_d = bus_io.message_authentication;
            pend_full   = 1'b1;
          end
          if (!bus_io.message_authentication) begin
            auth_fail_d  = 1'b1;
            fail_count_d = (fail_count_q == 8'hFF) ? 8'hFF : fail_count_q + 8'd1;
          end
        end else begin
          overflow_d = 1'b1;
        end
      end

      pend_valid_d = pend_full;
      state_d      = out_full ? StHold : StIdle;

`ifdef ASCON_RELEASE_LOCKOUT_EN
      if (fail_count_d >= FailLimit) begin
        state_d      = StLocked;
        out_data_d   = '0;
        out_tag_d    = '0;
        out_kind_d   = 1'b0;
        pend_valid_d = 1'b0;
      end
`endif
    end
  end

  assign bus_io.out_data   = out_data_q;
  assign bus_io.out_tag    = out_tag_q;
  assign bus_io.out_kind   = out_kind_q;
  assign bus_io.out_valid  = (state_q == StHold);
  assign bus_io.auth_fail  = auth_fail_q;
  assign bus_io.fail_count = fail_count_q;
  assign bus_io.overflow   = overflow_q;
  assign bus_io.locked     = lock_st;

endmodule

// File: tb/tb_ascon_release_ctrl.sv
// Bench for ascon_release_ctrl: a cycle table, hand sequences for reset/auth/lockout corners,
// and a randomized run against a queue-based reference model.
module tb_ascon_release_ctrl;
  localparam int unsigned Y = 40;
  localparam int unsigned Limit = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ascon_release_ctrl_if #(.y(Y)) bus_if ();

  ascon_release_ctrl #(.y(Y), .FAIL_LIMIT(Limit)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] etag(input logic [Y-1:0] d);
    return {8'hA5, d, d, d};
  endfunction

  function automatic logic [127:0] dtag(input logic [Y-1:0] d);
    return {8'h5A, d, ~d, d};
  endfunction

  task automatic drive(input logic enc, input logic dec, input logic auth, input logic rdy,
                       input logic [Y-1:0] ct, input logic [Y-1:0] pt);
    bus_if.encryption_ready       = enc;
    bus_if.decryption_ready       = dec;
    bus_if.message_authentication = auth;
    bus_if.out_ready              = rdy;
    bus_if.cipher_text            = ct;
    bus_if.tag                    = etag(ct);
    bus_if.dec_plain_text         = pt;
    bus_if.dec_tag                = dtag(pt);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic enc; logic dec; logic auth; logic rdy;
    logic [Y-1:0] ct; logic [Y-1:0] pt;
    logic v; logic kind; logic [Y-1:0] data; logic af; logic [7:0] fc; logic ovf;
  } vec_t;

  localparam logic [Y-1:0] K0 = 40'h12_3456_789A;
  localparam logic [Y-1:0] KA = 40'hA1_A1A1_A1A1, KB = 40'hB2_B2B2_B2B2, KC = 40'hC3_C3C3_C3C3;
  localparam logic [Y-1:0] KD = 40'hD4_D4D4_D4D4, KE = 40'hE5_E5E5_E5E5, KF = 40'hF6_F6F6_F6F6;
  localparam logic [Y-1:0] KG = 40'h17_1717_1717, KH = 40'h28_2828_2828;

  vec_t vecs[$];

  // Reference model: up to two results queued (output then pending), in arrival order.
  typedef struct { logic [Y-1:0] data; logic [127:0] tag; logic kind; } res_t;
  res_t mq[$];
  int   m_fc;
  bit   m_ovf, m_locked, m_af, m_prev_e, m_prev_d, m_arm_e, m_arm_d;

  task automatic model_step(input logic r, input logic enc, input logic dec, input logic auth,
                            input logic rdy, input logic [Y-1:0] ct, input logic [127:0] tg,
                            input logic [Y-1:0] pt, input logic [127:0] dtg);
    bit ee, ed;
    res_t it;
    if (r) begin
      mq.delete();
      m_fc = 0; m_ovf = 0; m_locked = 0; m_af = 0;
      m_prev_e = 0; m_prev_d = 0; m_arm_e = !enc; m_arm_d = !dec;
      return;
    end
    ee = enc && !m_prev_e && m_arm_e;
    ed = dec && !m_prev_d && m_arm_d;
    m_prev_e = enc; m_prev_d = dec;
    if (!enc) m_arm_e = 1;
    if (!dec) m_arm_d = 1;
    m_af = 0;
    if (m_locked) return;
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (ee) begin
      if (mq.size() < 2) begin
        it.data = ct; it.tag = tg; it.kind = 1'b0;
        mq.push_back(it);
      end else m_ovf = 1;
    end
    if (ed) begin
      if (mq.size() < 2) begin
        it.data = auth ? pt : '0; it.tag = auth ? dtg : '0; it.kind = 1'b1;
        mq.push_back(it);
        if (!auth) begin
          m_af = 1;
          if (m_fc < 255) m_fc++;
        end
      end else m_ovf = 1;
    end
`ifdef ASCON_RELEASE_LOCKOUT_EN
    if (m_fc >= int'(Limit)) begin
      m_locked = 1;
      mq.delete();
    end
`endif
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();
    check("reset_valid", 128'(bus_if.out_valid), 128'(0));
    check("reset_data", 128'(bus_if.out_data), 128'(0));
    check("reset_tag", bus_if.out_tag, 128'(0));
    check("reset_fc", 128'(bus_if.fail_count), 128'(0));
    check("reset_ovf", 128'(bus_if.overflow), 128'(0));
    check("reset_locked", 128'(bus_if.locked), 128'(0));

    // ---- Cycle table: inputs before each edge, outputs expected after it ----
    vecs.push_back('{0, 0, 1, 1, '0, '0, 0, 0, '0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 1, K0, '0, 1, 0, K0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 1, K0, '0, 0, 0, '0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 1, K0, '0, 0, 0, '0, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 1, K0, '0, 0, 0, '0, 0, 0, 0});
    vecs.push_back('{1, 1, 1, 1, KA, KB, 1, 0, KA, 0, 0, 0});
    vecs.push_back('{1, 1, 1, 1, KA, KB, 1, 1, KB, 0, 0, 0});
    vecs.push_back('{1, 1, 1, 1, KA, KB, 0, 0, '0, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 0, KA, KB, 0, 0, '0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 0, KC, KB, 1, 0, KC, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 0, KC, KD, 1, 0, KC, 0, 0, 0});
    vecs.push_back('{1, 1, 1, 0, KE, KD, 1, 0, KC, 0, 0, 1});
    vecs.push_back('{1, 1, 1, 1, KE, KD, 1, 1, KD, 0, 0, 1});
    vecs.push_back('{1, 1, 1, 1, KE, KD, 0, 0, '0, 0, 0, 1});
    vecs.push_back('{0, 0, 1, 0, KE, KD, 0, 0, '0, 0, 0, 1});
    vecs.push_back('{0, 1, 0, 0, KE, KF, 1, 1, '0, 1, 1, 1});
    vecs.push_back('{0, 1, 0, 0, KE, KF, 1, 1, '0, 0, 1, 1});
    vecs.push_back('{0, 1, 0, 1, KE, KF, 0, 0, '0, 0, 1, 1});
    vecs.push_back('{0, 0, 1, 0, KE, KF, 0, 0, '0, 0, 1, 1});
    vecs.push_back('{1, 0, 1, 0, KG, KF, 1, 0, KG, 0, 1, 1});
    vecs.push_back('{0, 1, 1, 1, KG, KH, 1, 1, KH, 0, 1, 1});
    vecs.push_back('{0, 1, 1, 0, KG, KH, 1, 1, KH, 0, 1, 1});
    vecs.push_back('{0, 1, 1, 1, KG, KH, 0, 0, '0, 0, 1, 1});

    foreach (vecs[i]) begin
      logic [127:0] et;
      drive(vecs[i].enc, vecs[i].dec, vecs[i].auth, vecs[i].rdy, vecs[i].ct, vecs[i].pt);
      tick();
      check($sformatf("vec%0d_valid", i), 128'(bus_if.out_valid), 128'(vecs[i].v));
      if (vecs[i].v) begin
        if (!vecs[i].kind) et = etag(vecs[i].data);
        else if (vecs[i].data != '0) et = dtag(vecs[i].data);
        else et = '0;
        check($sformatf("vec%0d_kind", i), 128'(bus_if.out_kind), 128'(vecs[i].kind));
        check($sformatf("vec%0d_data", i), 128'(bus_if.out_data), 128'(vecs[i].data));
        check($sformatf("vec%0d_tag", i), bus_if.out_tag, et);
      end
      check($sformatf("vec%0d_af", i), 128'(bus_if.auth_fail), 128'(vecs[i].af));
      check($sformatf("vec%0d_fc", i), 128'(bus_if.fail_count), 128'(vecs[i].fc));
      check($sformatf("vec%0d_ovf", i), 128'(bus_if.overflow), 128'(vecs[i].ovf));
      check($sformatf("vec%0d_locked", i), 128'(bus_if.locked), 128'(0));
    end

    // ---- Rejected decryption held under back-pressure ----
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, KF);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rej%0d_valid", i), 128'(bus_if.out_valid), 128'(1));
      check($sformatf("rej%0d_data", i), 128'(bus_if.out_data), 128'(0));
      check($sformatf("rej%0d_tag", i), bus_if.out_tag, 128'(0));
      check($sformatf("rej%0d_af", i), 128'(bus_if.auth_fail), 128'(i == 0));
      check($sformatf("rej%0d_fc", i), 128'(bus_if.fail_count), 128'(1));
    end
    bus_if.out_ready = 1'b1;
    tick();
    check("rej_release", 128'(bus_if.out_valid), 128'(0));

    // ---- Reset mid-HOLD with encryption_ready held high ----
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, KA, '0);
    tick();
    check("rsthold_valid", 128'(bus_if.out_valid), 128'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rsthold_cleared", 128'(bus_if.out_valid), 128'(0));
    repeat (3) begin
      tick();
      check("rsthold_nocap", 128'(bus_if.out_valid), 128'(0));
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, KB, '0);
    tick();
    check("rsthold_low", 128'(bus_if.out_valid), 128'(0));
    drive(1'b1, 1'b0, 1'b1, 1'b0, KB, '0);
    tick();
    check("rsthold_recap", 128'(bus_if.out_valid), 128'(1));
    check("rsthold_data", 128'(bus_if.out_data), 128'(KB));

`ifdef ASCON_RELEASE_LOCKOUT_EN
    // ---- Lockout after Limit failed decryptions ----
    do_reset();
    for (int k = 0; k < int'(Limit); k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, '0, KC);
      tick();
      check($sformatf("lock%0d_fc", k), 128'(bus_if.fail_count), 128'(k + 1));
      check($sformatf("lock%0d_locked", k), 128'(bus_if.locked), 128'(k == int'(Limit) - 1));
      drive(1'b0, 1'b0, 1'b1, 1'b1, '0, KC);
      tick();
    end
    check("lock_valid", 128'(bus_if.out_valid), 128'(0));
    check("lock_data", 128'(bus_if.out_data), 128'(0));
    drive(1'b1, 1'b0, 1'b1, 1'b1, KD, '0);
    tick();
    check("lock_ignore", 128'(bus_if.out_valid), 128'(0));
    check("lock_hold", 128'(bus_if.locked), 128'(1));
    do_reset();
    check("lock_rst_locked", 128'(bus_if.locked), 128'(0));
    check("lock_rst_fc", 128'(bus_if.fail_count), 128'(0));
`endif

    // ---- Randomized run against the reference model ----
    begin
      logic enc, dec, auth, rdy, r;
      logic [63:0] w;
      logic [Y-1:0] ct, pt;
      logic [127:0] tg, dtg;
      enc = 0; dec = 0;
      do_reset();
      model_step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
      for (int c = 0; c < 3000; c++) begin
        r = ($urandom_range(99) == 0);
        if ($urandom_range(3) == 0) enc = !enc;
        if ($urandom_range(3) == 0) dec = !dec;
        auth = ($urandom_range(5) != 0);
        rdy  = $urandom_range(1);
        w = {$urandom, $urandom}; ct = w[Y-1:0];
        w = {$urandom, $urandom}; pt = w[Y-1:0];
        tg  = {$urandom, $urandom, $urandom, $urandom};
        dtg = {$urandom, $urandom, $urandom, $urandom};
        rst = r;
        bus_if.encryption_ready = enc; bus_if.decryption_ready = dec;
        bus_if.message_authentication = auth; bus_if.out_ready = rdy;
        bus_if.cipher_text = ct; bus_if.tag = tg;
        bus_if.dec_plain_text = pt; bus_if.dec_tag = dtg;
        model_step(r, enc, dec, auth, rdy, ct, tg, pt, dtg);
        tick();
        check("rnd_valid", 128'(bus_if.out_valid), 128'(mq.size() > 0 && !m_locked));
        if (mq.size() > 0 && !m_locked) begin
          check("rnd_kind", 128'(bus_if.out_kind), 128'(mq[0].kind));
          check("rnd_data", 128'(bus_if.out_data), 128'(mq[0].data));
          check("rnd_tag", bus_if.out_tag, mq[0].tag);
        end
        if (m_locked) begin
          check("rnd_lock_data", 128'(bus_if.out_data), 128'(0));
          check("rnd_lock_tag", bus_if.out_tag, 128'(0));
        end
        check("rnd_af", 128'(bus_if.auth_fail), 128'(m_af));
        check("rnd_fc", 128'(bus_if.fail_count), 128'(m_fc));
        check("rnd_ovf", 128'(bus_if.overflow), 128'(m_ovf));
        check("rnd_locked", 128'(bus_if.locked), 128'(m_locked));
      end
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
